// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter: shares the DDR3 user port between scanout reads and render writes.
// Define FB_ARB_STATS_EN to add burst and starvation statistics outputs.
module fb_mem_arbiter #(
   parameter int ADDR_W     = 28,
   parameter int DATA_W     = 128,
   parameter int BURST_LEN  = 8,
   parameter int STARVE_MAX = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mem_init_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_grant,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   output logic              wr_grant,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_pop,
   output logic              mem_cmd_en,
   output logic              mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_cmd_ready,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_wr_en,
   input  logic              mem_wr_rdy,
   input  logic [DATA_W-1:0] mem_rd_data,
   input  logic              mem_rd_valid
`ifdef FB_ARB_STATS_EN
   ,
   output logic [15:0]       stat_rd_bursts,
   output logic [15:0]       stat_wr_bursts,
   output logic [15:0]       stat_starve
`endif
);

   localparam int          SW   = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] CAP  = SW'(STARVE_MAX);
   localparam logic [7:0]  LAST = 8'(BURST_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      RD_CMD,
      RD_WAIT,
      WR_DATA,
      WR_CMD
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        beat_cnt;
   logic [SW-1:0]     starve_cnt;
   logic              starved;
   logic              arb_ok;
   logic              go_rd;
   logic              go_wr;
   logic              rd_beat;

   // W is forced only when it is actually waiting and R has hogged the port.
   assign starved = wr_req && (starve_cnt >= CAP);
   assign arb_ok  = rst_n && mem_init_done && (state == IDLE);
   assign go_rd   = arb_ok && rd_req && !starved;
   assign go_wr   = arb_ok && wr_req && !go_rd;
   assign rd_beat = (state == RD_WAIT) && mem_rd_valid;

   always_comb begin
      state_nx   = state;
      rd_grant   = 1'b0;
      wr_grant   = 1'b0;
      mem_cmd_en = 1'b0;
      mem_cmd    = 1'b0;
      mem_wr_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (go_rd) begin
               rd_grant = 1'b1;
               state_nx = RD_CMD;
            end else if (go_wr) begin
               wr_grant = 1'b1;
               state_nx = WR_DATA;
            end
         end
         RD_CMD: begin
            mem_cmd_en = 1'b1;
            mem_cmd    = 1'b1;
            if (mem_cmd_ready) state_nx = RD_WAIT;
         end
         RD_WAIT: begin
            if (mem_rd_valid && beat_cnt == LAST) state_nx = IDLE;
         end
         WR_DATA: begin
            mem_wr_en = 1'b1;
            if (mem_wr_rdy && beat_cnt == LAST) state_nx = WR_CMD;
         end
         WR_CMD: begin
            mem_cmd_en = 1'b1;
            if (mem_cmd_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Strobes are silenced during reset so an abandoned burst emits nothing.
      if (!rst_n) begin
         state_nx   = IDLE;
         rd_grant   = 1'b0;
         wr_grant   = 1'b0;
         mem_cmd_en = 1'b0;
         mem_cmd    = 1'b0;
         mem_wr_en  = 1'b0;
      end
   end

   assign wr_pop      = mem_wr_en && mem_wr_rdy;
   assign mem_wr_data = mem_wr_en ? wr_data : '0;
   assign mem_addr    = addr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         addr_q   <= '0;
         beat_cnt <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_nx;
         rd_valid <= rd_beat;
         if (rd_beat) rd_data <= mem_rd_data;
         if (rd_grant) addr_q <= rd_addr;
         else if (wr_grant) addr_q <= wr_addr;
         if (rd_grant || wr_grant) begin
            beat_cnt <= '0;
         end else if (state == RD_CMD && mem_cmd_ready) begin
            beat_cnt <= '0;
         end else if (rd_beat || wr_pop) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (wr_grant) begin
         starve_cnt <= '0;
      end else if (state == IDLE && !wr_req) begin
         starve_cnt <= '0;
      end else if (rd_grant && wr_req && starve_cnt < CAP) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

`ifdef FB_ARB_STATS_EN
   logic rd_done;
   logic wr_done;

   assign rd_done = rd_beat && (beat_cnt == LAST);
   assign wr_done = (state == WR_CMD) && mem_cmd_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_rd_bursts <= '0;
         stat_wr_bursts <= '0;
         stat_starve    <= '0;
      end else begin
         if (rd_done) stat_rd_bursts <= stat_rd_bursts + 16'd1;
         if (wr_done) stat_wr_bursts <= stat_wr_bursts + 16'd1;
         // A W grant while R is also asking can only be a forced one.
         if (wr_grant && rd_req) stat_starve <= stat_starve + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// tb_fb_mem_arbiter: randomized bench for fb_mem_arbiter with queue scoreboards
// and a transaction-level arbitration model (priority, starvation, burst lengths).
module tb_fb_mem_arbiter;

   localparam int AW = 28;
   localparam int DW = 128;
   localparam int BL = 8;
   localparam int SM = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          mem_init_done;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_grant;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic          wr_grant;
   logic [DW-1:0] wr_data;
   logic          wr_pop;
   logic          mem_cmd_en;
   logic          mem_cmd;
   logic [AW-1:0] mem_addr;
   logic          mem_cmd_ready;
   logic [DW-1:0] mem_wr_data;
   logic          mem_wr_en;
   logic          mem_wr_rdy;
   logic [DW-1:0] mem_rd_data;
   logic          mem_rd_valid;
`ifdef FB_ARB_STATS_EN
   logic [15:0]   stat_rd_bursts;
   logic [15:0]   stat_wr_bursts;
   logic [15:0]   stat_starve;
`endif

   always #5 clk = ~clk;

   fb_mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .STARVE_MAX(SM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mem_init_done(mem_init_done),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
      .rd_data(rd_data), .rd_valid(rd_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(wr_grant),
      .wr_data(wr_data), .wr_pop(wr_pop),
      .mem_cmd_en(mem_cmd_en), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .mem_cmd_ready(mem_cmd_ready), .mem_wr_data(mem_wr_data),
      .mem_wr_en(mem_wr_en), .mem_wr_rdy(mem_wr_rdy),
      .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
`ifdef FB_ARB_STATS_EN
      ,
      .stat_rd_bursts(stat_rd_bursts), .stat_wr_bursts(stat_wr_bursts),
      .stat_starve(stat_starve)
`endif
   );

   typedef struct { logic [DW-1:0] d; int t; } rbeat_t;
   typedef struct { logic c; logic [AW-1:0] a; } cmd_t;

   rbeat_t        exp_rd[$];
   cmd_t          exp_cmd[$];
   logic [DW-1:0] exp_wr[$];
   logic [DW-1:0] wr_fifo[$];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // monitor -> driver handshake flags, refreshed every falling edge
   bit f_rg, f_wg, f_rcmd, f_pop;
   // transaction-level model state
   bit busy, wphase, idle_now, forced, exp_r, stall_q, rst_q;
   int starve, rleft, wbeats;
   int n_rdv, n_pop, n_rg, n_rg_at_wg;
   cmd_t   stall_c, c;
   rbeat_t b;

   // stimulus knobs
   int p_rd, p_wr, p_rdy, p_wrdy, p_beat, rd_pend, hold_cnt;
   bit hold_on_grant;

   function automatic void check(string nm, logic [159:0] act,
                                 logic [159:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endfunction

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor / reference model
   initial forever begin
      @(negedge clk);
      f_rg = 0; f_wg = 0; f_rcmd = 0; f_pop = 0;
      if (!rst_n) begin
         check("rst_strobes",
               {rd_grant, wr_grant, wr_pop, mem_cmd_en, mem_wr_en}, 0);
         if (rst_q)
            check("rst_outputs", {rd_valid, mem_cmd, |rd_data,
                                  |mem_addr, |mem_wr_data}, 0);
         rst_q = 1; busy = 0; wphase = 0; starve = 0; rleft = 0;
         wbeats = 0; stall_q = 0;
         exp_cmd.delete();
         continue;
      end
      rst_q = 0;
      idle_now = !busy;

      if (stall_q)
         check("cmd_stable", {mem_cmd_en, mem_cmd, mem_addr},
               {1'b1, stall_c.c, stall_c.a});
      if (mem_cmd_en && mem_cmd_ready) begin
         if (exp_cmd.size() == 0) begin
            check("cmd_unexpected", {mem_cmd, mem_addr}, 0);
         end else begin
            c = exp_cmd.pop_front();
            check("cmd", {mem_cmd, mem_addr}, {c.c, c.a});
            if (c.c) begin
               rleft = BL; f_rcmd = 1;
            end else begin
               check("wr_beats_before_cmd", wbeats, BL);
               wphase = 0; busy = 0;
            end
         end
      end
      stall_q = mem_cmd_en && !mem_cmd_ready;
      stall_c = '{mem_cmd, mem_addr};

      if (mem_wr_en || (wphase && wbeats < BL))
         check("wr_en", mem_wr_en, wphase && wbeats < BL);
      if (mem_wr_en || wr_pop)
         check("wr_pop", wr_pop, mem_wr_en && mem_wr_rdy);
      if (mem_wr_en && mem_wr_rdy) begin
         if (exp_wr.size() == 0) check("wr_data_extra", mem_wr_data, 0);
         else check("wr_data", mem_wr_data, exp_wr.pop_front());
         wbeats++;
      end
      if (wr_pop) begin
         f_pop = 1; n_pop++;
      end

      if (mem_rd_valid && rleft > 0) begin
         rleft--;
         if (rleft == 0) busy = 0;
      end
      if (rd_valid) begin
         n_rdv++;
         if (exp_rd.size() == 0) begin
            check("rd_unexpected", rd_data, 0);
         end else begin
            b = exp_rd.pop_front();
            check("rd_data", rd_data, b.d);
            check("rd_latency", cyc, b.t);
         end
      end else if (exp_rd.size() != 0 && exp_rd[0].t <= cyc) begin
         check("rd_missing", rd_valid, 1);
         void'(exp_rd.pop_front());
      end

      if (idle_now && !wr_req) starve = 0;
      if (idle_now && (rd_req || wr_req))
         check("grant_fire", rd_grant || wr_grant, mem_init_done);
      if (rd_grant || wr_grant) begin
         forced = rd_req && wr_req && starve >= SM;
         exp_r  = rd_req && !forced;
         check("grant_legal", {rd_grant && wr_grant, !idle_now,
               !mem_init_done, !(rd_grant ? rd_req : wr_req)}, 0);
         check("grant_winner", {rd_grant, wr_grant},
               exp_r ? 2'b10 : 2'b01);
         if (rd_grant) begin
            exp_cmd.push_back('{1'b1, rd_addr});
            if (wr_req && starve < SM) starve++;
            f_rg = 1; n_rg++;
         end else begin
            exp_cmd.push_back('{1'b0, wr_addr});
            starve = 0; wphase = 1; wbeats = 0;
            f_wg = 1; n_rg_at_wg = n_rg;
         end
         busy = 1;
      end
   end

   function automatic void raise_wr(logic [AW-1:0] a);
      logic [DW-1:0] d;
      wr_req  = 1;
      wr_addr = a;
      for (int i = 0; i < BL; i++) begin
         d = rnd_data();
         wr_fifo.push_back(d);
         exp_wr.push_back(d);
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      if (f_pop && wr_fifo.size() != 0) void'(wr_fifo.pop_front());
      if (f_rg) begin
         rd_req = 0;
         if (hold_on_grant) begin
            hold_cnt = 10; hold_on_grant = 0;
         end
      end
      if (f_wg) wr_req = 0;
      if (!rd_req && $urandom_range(99) < p_rd) begin
         rd_req = 1; rd_addr = AW'($urandom);
      end
      if (!wr_req && $urandom_range(99) < p_wr) raise_wr(AW'($urandom));
      wr_data = (wr_fifo.size() != 0) ? wr_fifo[0] : '0;
      if (f_rcmd) rd_pend = BL;
      if (rd_pend > 0 && $urandom_range(99) < p_beat) begin
         mem_rd_valid = 1;
         mem_rd_data  = rnd_data();
         exp_rd.push_back('{mem_rd_data, cyc + 1});
         rd_pend--;
      end else begin
         mem_rd_valid = 0;
      end
      if (hold_cnt > 0) begin
         mem_cmd_ready = 0; hold_cnt--;
      end else begin
         mem_cmd_ready = ($urandom_range(99) < p_rdy);
      end
      mem_wr_rdy = ($urandom_range(99) < p_wrdy);
   endtask

   task automatic run_idle(int budget, string nm);
      int n = 0;
      while (n < budget && (busy || rd_req || wr_req ||
             exp_rd.size() != 0 || exp_cmd.size() != 0)) begin
         step();
         n++;
      end
      check({nm, "_timeout"}, n < budget, 1);
   endtask

   task automatic do_reset(int cycles);
      rst_n = 0; rd_req = 0; wr_req = 0;
      wr_fifo.delete(); exp_wr.delete(); exp_rd.delete();
      rd_pend = 0; hold_cnt = 0; mem_rd_valid = 0;
      repeat (cycles) step();
      rst_n = 1;
   endtask

   int base, k;

   initial begin
      rst_n = 0; mem_init_done = 1;
      rd_req = 1; rd_addr = 28'h55;
      wr_req = 0; wr_addr = '0; wr_data = '0;
      mem_cmd_ready = 0; mem_wr_rdy = 0;
      mem_rd_data = '0; mem_rd_valid = 0;
      p_rd = 0; p_wr = 0; p_rdy = 100; p_wrdy = 100; p_beat = 100;
      rd_pend = 0; hold_cnt = 0; hold_on_grant = 0;

      // reset with a pending request, then calibration not yet done
      repeat (3) step();
      mem_init_done = 0;
      rst_n = 1;
      repeat (5) step();
      rd_req = 0;
      mem_init_done = 1;
      step();

      // single read burst
      base = n_rdv;
      rd_req = 1; rd_addr = 28'h100;
      run_idle(200, "t2");
      check("t2_rd_beats", n_rdv - base, BL);

      // single write burst with toggling write ready
      p_wrdy = 50;
      base = n_pop;
      raise_wr(28'h200);
      run_idle(300, "t3");
      check("t3_wr_pops", n_pop - base, BL);

      // command held off by the controller
      p_rdy = 100;
      hold_on_grant = 1;
      rd_req = 1; rd_addr = 28'h4000;
      run_idle(200, "t5");

      // sustained contention: reads always asking, one write waiting
      base = n_rg;
      p_rd = 100; p_wrdy = 100;
      rd_req = 1; rd_addr = 28'h1234;
      raise_wr(28'h777);
      repeat (400) step();
      check("t4_reads_before_write", n_rg_at_wg - base, SM);
      p_rd = 0;
      run_idle(300, "t4");

      // reset during write beat 4
      p_wrdy = 100;
      raise_wr(28'h300);
      k = 0;
      while (k < 100 && !(wphase && wbeats >= 4)) begin
         step();
         k++;
      end
      check("t6_reach_beat4", k < 100, 1);
      do_reset(2);
      repeat (12) step();

      // randomized traffic
      p_rd = 30; p_wr = 30; p_rdy = 60; p_wrdy = 60; p_beat = 70;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(99) < 2) mem_init_done = ~mem_init_done;
         step();
      end
      p_rd = 0; p_wr = 0; mem_init_done = 1;
      run_idle(2000, "drain");
      check("drain_queues",
            exp_cmd.size() + exp_rd.size() + exp_wr.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
